// File: rtl/pipe_seg_reg.sv
// Pipeline segment register with a two-entry main/skid buffer.
// Every output comes straight from a flop. in_ready has no combinational
// path from out_ready. Flush inserts a bubble and takes priority over both
// handshakes.
module pipe_seg_reg #(
   parameter int DATA_W     = 32,
   parameter int CTRL_W     = 24,
   parameter int CLEAR_DATA = 1,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              main_valid, skid_valid;
   logic [DATA_W-1:0] main_data, skid_data;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
   logic              in_fire, out_fire, main_free;

   // The skid entry is the only reason to refuse input.
   assign in_ready  = ~skid_valid;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = main_valid & out_ready;
   // Main may take new content this edge: it is empty or handing off downstream.
   assign main_free = ~main_valid | out_fire;

   assign out_valid = main_valid;
   assign out_data  = main_data;
   // A bubble must never carry register or memory write enables.
   assign out_ctrl  = main_valid ? main_ctrl : '0;

   // Occupancy and control payload; flush zeroes control unconditionally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_ctrl  <= '0;
         skid_ctrl  <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_ctrl  <= '0;
         skid_ctrl  <= '0;
      end else if (main_free) begin
         if (skid_valid) begin
            // Skid is older than anything upstream; in_ready was low, so no input fired.
            main_valid <= 1'b1;
            main_ctrl  <= skid_ctrl;
            skid_valid <= 1'b0;
         end else if (in_fire) begin
            main_valid <= 1'b1;
            main_ctrl  <= in_ctrl;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (in_fire) begin
         // Main is stalled, so the accepted payload is parked behind it.
         skid_valid <= 1'b1;
         skid_ctrl  <= in_ctrl;
      end
   end

   // Data payload follows the same moves. Flush clears it only when CLEAR_DATA is set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_data <= '0;
         skid_data <= '0;
      end else if (flush) begin
         if (CLEAR_DATA != 0) begin
            main_data <= '0;
            skid_data <= '0;
         end
      end else if (main_free) begin
         if (skid_valid)
            main_data <= skid_data;
         else if (in_fire)
            main_data <= in_data;
      end else if (in_fire) begin
         skid_data <= in_data;
      end
   end

   // Saturating count of downstream back-pressure cycles. Flush does not clear it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end

endmodule

// File: tb/tb_pipe_seg_reg.sv
// Bench for pipe_seg_reg. It combines a vector table, a FIFO scoreboard
// and hand-written reset/flush/saturation sequences.
module tb_pipe_seg_reg;

   localparam int DW = 32;
   localparam int CW = 24;
   localparam int NW = 4;

   logic          clk = 1'b0;
   logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [NW-1:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: an ordered list of payloads in flight, plus the stall count.
   logic [31:0] exp_q[$];
   int          exp_cnt = 0;

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        fl;
      logic        e_vld;
      logic [31:0] e_data;
      logic        e_rdy;
   } vec_t;

   vec_t tbl[16];

   pipe_seg_reg #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1), .CNT_W(NW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] mkc(input logic [31:0] d);
      return d[23:0] ^ 24'hA5A5A5;
   endfunction

   function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic ordy,
                               input logic fl, input logic ev, input logic [31:0] ed,
                               input logic er);
      vec_t v;
      v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
      v.e_vld = ev; v.e_data = ed; v.e_rdy = er;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      chk("sb_out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      chk("sb_in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      chk("sb_stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
      if (exp_q.size() > 0) begin
         chk("sb_out_data", out_data, exp_q[0]);
         chk("sb_out_ctrl", 32'(out_ctrl), 32'(mkc(exp_q[0])));
      end else begin
         chk("sb_bubble_ctrl", 32'(out_ctrl), 32'd0);
      end
   endtask

   // Drive one cycle. Update the model from its pre-edge state, then check 1 time unit after the edge.
   task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
      int  sz;
      bit  f_in, f_out, st;
      in_valid = iv; in_data = d; in_ctrl = mkc(d); out_ready = ordy; flush = fl;
      sz    = exp_q.size();
      f_in  = iv && (sz < 2);
      f_out = ordy && (sz > 0);
      st    = (sz > 0) && !ordy;
      @(posedge clk);
      #1;
      if (st && exp_cnt < 15) exp_cnt++;
      if (fl) exp_q.delete();
      else begin
         if (f_out) void'(exp_q.pop_front());
         if (f_in) exp_q.push_back(d);
      end
      model_check();
   endtask

   initial begin
      // Streaming.
      tbl[0]  = mk(1, 32'h10, 1, 0, 1, 32'h10, 1);
      tbl[1]  = mk(1, 32'h14, 1, 0, 1, 32'h14, 1);
      tbl[2]  = mk(1, 32'h18, 1, 0, 1, 32'h18, 1);
      tbl[3]  = mk(0, 32'h0,  1, 0, 0, 32'h0,  1);
      // Stall: A in main, B in skid, C refused; release drains A then B.
      tbl[4]  = mk(1, 32'hA0, 0, 0, 1, 32'hA0, 1);
      tbl[5]  = mk(1, 32'hB0, 0, 0, 1, 32'hA0, 0);
      tbl[6]  = mk(1, 32'hC0, 0, 0, 1, 32'hA0, 0);
      tbl[7]  = mk(0, 32'h0,  1, 0, 1, 32'hB0, 1);
      tbl[8]  = mk(0, 32'h0,  1, 0, 0, 32'h0,  1);
      // Flush with skid full.
      tbl[9]  = mk(1, 32'hA1, 0, 0, 1, 32'hA1, 1);
      tbl[10] = mk(1, 32'hB1, 0, 0, 1, 32'hA1, 0);
      tbl[11] = mk(0, 32'h0,  0, 1, 0, 32'h0,  1);
      tbl[12] = mk(0, 32'h0,  1, 0, 0, 32'h0,  1);
      // Flush coincident with an input fire.
      tbl[13] = mk(1, 32'hC1, 1, 0, 1, 32'hC1, 1);
      tbl[14] = mk(1, 32'hD1, 1, 1, 0, 32'h0,  1);
      tbl[15] = mk(0, 32'h0,  1, 0, 0, 32'h0,  1);

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_ctrl = '0;
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_ctrl", 32'(out_ctrl), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_vld));
         chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
         if (tbl[i].e_vld) chk($sformatf("vec%0d_data", i), out_data, tbl[i].e_data);
         else chk($sformatf("vec%0d_ctrl0", i), 32'(out_ctrl), 32'd0);
      end
      // Stall cycles so far: two during vectors 5-6 and two during vectors 10-11.
      chk("stall_after_table", 32'(stall_cnt), 32'd4);

      // Flush clears the data path as well.
      step(1, 32'hE0, 0, 0);
      step(0, 32'h0, 0, 1);
      chk("flush_data_zero", out_data, 32'd0);

      // Saturation of the 4-bit counter.
      step(1, 32'h55, 0, 0);
      repeat (20) step(0, 32'h0, 0, 0);
      chk("stall_saturated", 32'(stall_cnt), 32'd15);

      // Asynchronous reset mid-stall with both entries full.
      step(1, 32'h66, 0, 0);
      chk("both_full_ready", 32'(in_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_ctrl", 32'(out_ctrl), 32'd0);
      chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      exp_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 32'h77, 1, 0);
      chk("post_rst_latency", out_data, 32'h77);
      step(0, 32'h0, 1, 0);

      // Random traffic against the scoreboard.
      for (int i = 0; i < 200; i++)
         step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) != 0,
              $urandom_range(0, 19) == 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
